// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
// Holds the FSM state encoding, the AddrMode constants and the byte-lane helpers.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } dmemState_t;

   localparam logic ADDR_MODE_WORD = 1'b0;
   localparam logic ADDR_MODE_BYTE = 1'b1;

   // Byte-enable pattern for a store: all lanes for a word, one lane for a byte.
   function automatic logic [3:0] laneStrobe(input logic mode, input logic [1:0] lane);
      logic [3:0] strobe;
      if (mode == ADDR_MODE_BYTE) begin
         strobe = 4'b0001 << lane;
      end else begin
         strobe = 4'b1111;
      end
      return strobe;
   endfunction

   function automatic logic [31:0] laneExtract(input logic [31:0] word, input logic [1:0] lane);
      logic [31:0] value;
      case (lane)
         2'd0:    value = {24'd0, word[7:0]};
         2'd1:    value = {24'd0, word[15:8]};
         2'd2:    value = {24'd0, word[23:16]};
         2'd3:    value = {24'd0, word[31:24]};
         default: value = 32'd0;
      endcase
      return value;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-lane data storage: four byte-wide lanes sharing one word index.
// Synchronous strobed write, combinational word read; contents are never reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk,
   input  logic [3:0]            wrStrobe,
   input  logic [ADDR_WIDTH-3:0] wordAddr,
   input  logic [31:0]           wrData,
   output logic [31:0]           rdData
);

   localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

   for (genvar g = 0; g < 4; g++) begin : gLane
      logic [7:0] laneMem [WORDS];

      // Lane write, gated by its strobe bit.
      always_ff @(posedge clk) begin
         if (wrStrobe[g]) begin
            laneMem[wordAddr] <= wrData[8*g +: 8];
         end
      end

      assign rdData[8*g +: 8] = laneMem[wordAddr];
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the data-memory port: one request at a time,
// fixed access latency, one-cycle response pulse and a stall line to the hazard unit.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 17,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic                  req_addr_mode,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  stall
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   dmemState_t            state;
   logic [CW-1:0]         count;
   logic                  capWrite;
   logic                  capMode;
   logic [ADDR_WIDTH-1:0] capAddr;
   logic [DATA_WIDTH-1:0] capWdata;

   logic                  commit;
   logic [3:0]            wrStrobe;
   logic [31:0]           wrData;
   logic [31:0]           rdWord;
   logic [31:0]           loadData;

   // Address bits above the decoded range are dropped, which gives the wrap.
   logic unusedAddrHigh;
   assign unusedAddrHigh = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

   assign commit = (state == ACCESS) && (count == {CW{1'b0}});

   // Lane select for stores and zero-extended lane extraction for loads.
   always_comb begin
      wrStrobe = 4'b0000;
      wrData   = capWdata;
      loadData = rdWord;
      if (commit && capWrite) begin
         wrStrobe = laneStrobe(capMode, capAddr[1:0]);
      end else begin
         wrStrobe = 4'b0000;
      end
      if (capMode == ADDR_MODE_BYTE) begin
         wrData   = {4{capWdata[7:0]}};
         loadData = laneExtract(rdWord, capAddr[1:0]);
      end else begin
         wrData   = capWdata;
         loadData = rdWord;
      end
   end

   dmem_array #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) uArray (
      .clk      (clk),
      .wrStrobe (wrStrobe),
      .wordAddr (capAddr[ADDR_WIDTH-1:2]),
      .wrData   (wrData),
      .rdData   (rdWord)
   );

   // Request FSM with capture registers and registered response outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         count      <= {CW{1'b0}};
         capWrite   <= 1'b0;
         capMode    <= ADDR_MODE_WORD;
         capAddr    <= {ADDR_WIDTH{1'b0}};
         capWdata   <= {DATA_WIDTH{1'b0}};
         resp_valid <= 1'b0;
         resp_rdata <= {DATA_WIDTH{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               resp_valid <= 1'b0;
               resp_rdata <= {DATA_WIDTH{1'b0}};
               if (req_valid) begin
                  capWrite <= req_write;
                  capMode  <= req_addr_mode;
                  capAddr  <= req_addr[ADDR_WIDTH-1:0];
                  capWdata <= req_wdata;
                  count    <= CW'(LATENCY - 1);
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (count == {CW{1'b0}}) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= capWrite ? {DATA_WIDTH{1'b0}} : loadData;
               end else begin
                  count <= count - CW'(1);
               end
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_rdata <= {DATA_WIDTH{1'b0}};
            end
            default: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_rdata <= {DATA_WIDTH{1'b0}};
            end
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign stall     = ((state == IDLE) && req_valid) || (state == ACCESS);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic checked against a byte-level memory model.
module tb_dmem_responder;

   localparam int DW  = 32;
   localparam int AW  = 17;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_write;
   logic          req_addr_mode;
   logic [DW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          req_ready;
   logic          resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          stall;

   int checks   = 0;
   int failures = 0;

   // Observations from the last transaction
   bit          obsGot;
   int          obsLat;
   int          obsStall;
   logic [31:0] obsRdata;
   logic        obsRespStall;
   logic        obsReadyResp;
   logic        obsValidAfter;

   logic [7:0] mem [int unsigned];

   always #5 clk = ~clk;

   dmem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_write     (req_write),
      .req_addr_mode (req_addr_mode),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_ready     (req_ready),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .stall         (stall)
   );

   function automatic logic [7:0] memByte(input int unsigned a);
      if (mem.exists(a)) return mem[a];
      return 8'h00;
   endfunction

   // Reference behaviour: applies the access to the model and returns the expected response data.
   function automatic logic [31:0] modelAccess(input logic w, input logic m, input logic [31:0] a,
                                               input logic [31:0] d);
      int unsigned ea = a % (32'd1 << AW);
      if (m == 1'b0) ea = ea - (ea % 4);
      if (w) begin
         if (m) mem[ea] = d[7:0];
         else for (int k = 0; k < 4; k++) mem[ea + k] = d[8*k +: 8];
         return 32'd0;
      end
      if (m) return {24'd0, memByte(ea)};
      return {memByte(ea + 3), memByte(ea + 2), memByte(ea + 1), memByte(ea)};
   endfunction

   task automatic doReq(input logic w, input logic m, input logic [31:0] a, input logic [31:0] d);
      obsGot = 0; obsLat = -1; obsStall = 0; obsRdata = 32'd0;
      obsRespStall = 1'b1; obsReadyResp = 1'b1; obsValidAfter = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr_mode = m; req_addr = a; req_wdata = d;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (resp_valid) begin
            obsGot = 1; obsLat = i; obsRdata = resp_rdata;
            obsRespStall = stall; obsReadyResp = req_ready;
            break;
         end
         if (stall) obsStall++;
         @(posedge clk);
         #1;
         if (i == 0) begin
            req_valid = 1'b0;
            req_write = 1'($urandom); req_addr_mode = 1'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
         end
         @(negedge clk);
      end
      if (obsGot) begin
         @(negedge clk);
         #1;
         obsValidAfter = resp_valid;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr_mode = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b1) begin failures++; $display("FAIL reset_stall_follows got=%b want=1", stall); end
      req_valid = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall_low got=%b want=0", stall); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || req_ready !== 1'b1 || stall !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs got valid=%b rdata=%h ready=%b stall=%b want 0/0/1/0",
                  resp_valid, resp_rdata, req_ready, stall);
      end
   endtask

   task automatic test_word();
      void'(modelAccess(1'b1, 1'b0, 32'h100, 32'hDEADBEEF));
      doReq(1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
      checks++;
      if (!obsGot) begin failures++; $display("FAIL word_store_timeout got=none want=resp"); end
      checks++;
      if (obsLat !== LAT + 1) begin failures++; $display("FAIL word_store_latency got=%0d want=%0d", obsLat, LAT + 1); end
      checks++;
      if (obsStall !== LAT + 1) begin failures++; $display("FAIL word_store_stall got=%0d want=%0d", obsStall, LAT + 1); end
      checks++;
      if (obsRespStall !== 1'b0 || obsReadyResp !== 1'b0) begin
         failures++; $display("FAIL resp_cycle_flags got stall=%b ready=%b want 0/0", obsRespStall, obsReadyResp);
      end
      checks++;
      if (obsRdata !== 32'd0) begin failures++; $display("FAIL store_rdata got=%h want=0", obsRdata); end
      checks++;
      if (obsValidAfter !== 1'b0) begin failures++; $display("FAIL resp_pulse_width got=%b want=0", obsValidAfter); end
      doReq(1'b0, 1'b0, 32'h100, 32'h0);
      checks++;
      if (!obsGot || obsRdata !== 32'hDEADBEEF) begin
         failures++; $display("FAIL word_load got=%h want=deadbeef", obsRdata);
      end
   endtask

   task automatic test_lanes();
      void'(modelAccess(1'b1, 1'b0, 32'h200, 32'h11223344));
      void'(modelAccess(1'b1, 1'b1, 32'h202, 32'h000000AA));
      doReq(1'b1, 1'b0, 32'h200, 32'h11223344);
      doReq(1'b1, 1'b1, 32'h202, 32'hFFFFFFAA);
      doReq(1'b0, 1'b0, 32'h200, 32'h0);
      checks++;
      if (obsRdata !== 32'h11AA3344) begin failures++; $display("FAIL lane_word_load got=%h want=11aa3344", obsRdata); end
      doReq(1'b0, 1'b1, 32'h203, 32'h0);
      checks++;
      if (obsRdata !== 32'h00000011) begin failures++; $display("FAIL lane_byte_load got=%h want=00000011", obsRdata); end
      doReq(1'b0, 1'b0, 32'h201, 32'h0);
      checks++;
      if (obsRdata !== 32'h11AA3344) begin failures++; $display("FAIL misaligned_load got=%h want=11aa3344", obsRdata); end
   endtask

   task automatic test_wrap();
      void'(modelAccess(1'b1, 1'b0, (32'd1 << AW) + 32'h10, 32'h5A5A5A5A));
      doReq(1'b1, 1'b0, (32'd1 << AW) + 32'h10, 32'h5A5A5A5A);
      doReq(1'b0, 1'b0, 32'h10, 32'h0);
      checks++;
      if (obsRdata !== 32'h5A5A5A5A) begin failures++; $display("FAIL wrap_load got=%h want=5a5a5a5a", obsRdata); end
   endtask

   task automatic test_reset_mid_access();
      int seen = 0;
      void'(modelAccess(1'b1, 1'b0, 32'h300, 32'h0));
      doReq(1'b1, 1'b0, 32'h300, 32'h0);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr_mode = 1'b0;
      req_addr = 32'h300; req_wdata = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (resp_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin failures++; $display("FAIL abort_no_resp got=%0d pulses want=0", seen); end
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b want=1", req_ready); end
      doReq(1'b0, 1'b0, 32'h300, 32'h0);
      checks++;
      if (obsRdata !== modelAccess(1'b0, 1'b0, 32'h300, 32'h0)) begin
         failures++; $display("FAIL abort_store_discarded got=%h want=00000000", obsRdata);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp;
      logic        w;
      logic        m;
      logic [31:0] a;
      logic [31:0] d;
      for (int k = 0; k < 16; k++) begin
         d = $urandom;
         void'(modelAccess(1'b1, 1'b0, 32'h400 + 32'(4 * k), d));
         doReq(1'b1, 1'b0, 32'h400 + 32'(4 * k), d);
      end
      for (int n = 0; n < 40; n++) begin
         w = 1'($urandom);
         m = 1'($urandom);
         a = 32'h400 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << AW);
         d = $urandom;
         exp = modelAccess(w, m, a, d);
         doReq(w, m, a, d);
         checks++;
         if (!obsGot || obsLat !== LAT + 1 || obsRdata !== exp) begin
            failures++;
            $display("FAIL random_op%0d w=%b m=%b a=%h got=%h lat=%0d want=%h lat=%0d",
                     n, w, m, a, obsRdata, obsLat, exp, LAT + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_lanes();
      test_wrap();
      test_reset_mid_access();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
